unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
- Sequences one outstanding memory transaction at a time and gives data accesses priority over fetch.
- Generates the structural-hazard stall that freezes PC and IF/ID, and the stall that freezes the whole pipeline while a data access is in flight.
- Sits beside the load-use hazard logic; the top level ORs its stall outputs with the load-use stall.

Parameters:
- XLEN, 32, address/data width.
- MAX_WAIT, 15, cycles allowed without mem_ready before the transaction is aborted with err; 4-bit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF stage requests a fetch
- if_addr  in  XLEN  fetch address (PC)
- if_rdata  out  XLEN  fetched instruction
- if_valid  out  1  one-cycle pulse: if_rdata valid
- d_rd  in  1  MEM stage load request (EX/MEM MemRead)
- d_wr  in  1  MEM stage store request (EX/MEM MemWrite)
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_be  in  4  store byte enables
- d_rdata  out  XLEN  load data
- d_valid  out  1  one-cycle pulse: data access complete
- stall_if  out  1  hold PC and IF/ID
- stall_pipe  out  1  hold all pipeline registers (data access pending)
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_addr  out  XLEN  memory address
- m_wdata  out  XLEN  memory write data
- m_be  out  4  memory byte enables
- m_rdata  in  XLEN  memory read data
- m_ready  in  1  memory completes the current request this cycle
- err  out  1  sticky: timeout occurred; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state IDLE; m_req, m_we, if_valid, d_valid, err = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; m_be = 0; wait counter = 0.
- State IDLE:
  - (d_rd|d_wr)=1: grant data, go D_BUSY. This holds even when if_req=1; data always wins.
  - Otherwise if_req=1: go I_BUSY.
  - Otherwise stay in IDLE.
  - Request fields are registered on grant and held stable until completion.
- D_BUSY:
  - m_req=1, m_we=d_wr (latched), m_be = d_be for a store and 4'hF for a load.
  - stall_pipe=1 and stall_if=1 until the m_ready cycle.
  - On m_ready: d_valid pulses next cycle and d_rdata is latched (loads only; stores leave d_rdata unchanged).
  - Returns to IDLE.
- I_BUSY:
  - m_req=1, m_we=0, m_be=4'hF, stall_if=1.
  - On m_ready: if_rdata latched, if_valid pulses next cycle, return to IDLE.
  - A data request arriving during I_BUSY is not preempted. stall_pipe=1 (combinational) until the fetch completes and the data access is granted.
- Stall outputs are combinational from state and requests, so a request in IDLE stalls in the same cycle:
  - stall_if = if_req & ~(state==I_BUSY & m_ready), OR any data activity.
  - stall_pipe = (d_rd|d_wr) & ~(state==D_BUSY & m_ready).
- Minimum latency: request cycle → memory cycle with m_ready → valid pulse. Back-to-back transactions insert one IDLE cycle.
- d_rd & d_wr both set: treated as a store.
- Timeout:
  - The wait counter increments each busy cycle without m_ready.
  - On reaching MAX_WAIT: abort, err=1, return to IDLE, pulse the matching valid with rdata = 32'h00000013 (NOP) for fetch or 0 for data.
- m_ready in IDLE is ignored.
- Address is passed unchanged; no alignment check.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds two 32-bit saturating output counters.
  - conflict_cnt increments each cycle in which if_req=1 and data holds the grant.
  - busy_cnt increments each cycle m_req=1.
  - Both reset to 0 and stop at 32'hFFFFFFFF.
- ARB_PERF_CNT_EN undefined: neither the ports nor the logic exist.

Decomposition:
- Shared package holds:
  - arbiter state enum (IDLE, D_BUSY, I_BUSY)
  - NOP_INSTR = 32'h00000013
  - BE_ALL = 4'hF
- Natural sub-module: arb_wait_timer (counter, clear/enable, timeout flag), reused for the timeout logic.

Test Plan:
- if_req=1, if_addr=0x10, m_ready one cycle later, m_rdata=0x00500093 → if_valid pulse with if_rdata=0x00500093; stall_if high for exactly 2 cycles.
- Same-cycle if_req=1 and d_rd=1, d_addr=0x100 → m_addr=0x100 first, m_we=0; fetch issued only after d_valid; stall_if held throughout.
- d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011 → m_we=1, m_be=0011, m_wdata=0xDEADBEEF; d_rdata unchanged.
- d_rd arrives during I_BUSY → no preemption; stall_pipe=1 until fetch completes, then the data access is granted.
- m_ready held 0 for MAX_WAIT cycles on a fetch → err=1, if_valid with if_rdata=0x00000013, state IDLE.
- rst_n driven low mid D_BUSY → all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  BE_ALL    = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified arbiter: the arbiter is master, the memory is slave.
interface unified_mem_arbiter_if #(
  parameter int XLEN = 32
);

  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [3:0]      m_be;
  logic [XLEN-1:0] m_rdata;
  logic            m_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/arb_wait_timer.sv
// Wait-cycle counter for the arbiter: counts enabled cycles and flags the LIMIT-th one.
module arb_wait_timer #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  logic [WIDTH-1:0] r_count;

  // Fires during the LIMIT-th consecutive enabled cycle so the owner can abort at that edge.
  assign o_timeout = i_en && (r_count == WIDTH'(LIMIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_timeout) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-ported unified memory: data accesses beat fetches, one transaction at a time.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            d_rd,
  input  logic            d_wr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            stall_if,
  output logic            stall_pipe,
  unified_mem_arbiter_if.master mem,
  output logic            err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [31:0]     busy_cnt
`endif
);

  arb_state_e      r_state, w_next_state;
  logic            w_d_req, w_busy, w_timeout;
  logic            w_grant_d, w_grant_i;
  logic            r_we;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_if_rdata, r_d_rdata;
  logic            r_if_valid, r_d_valid, r_err;

  assign w_d_req = d_rd | d_wr;
  assign w_busy  = (r_state != IDLE);

  arb_wait_timer #(
    .WIDTH (4),
    .LIMIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (~w_busy),
    .i_en      (w_busy & ~mem.m_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req) begin
          w_next_state = D_BUSY;
          w_grant_d    = 1'b1;
        end else if (if_req) begin
          w_next_state = I_BUSY;
          w_grant_i    = 1'b1;
        end
      end
      D_BUSY, I_BUSY: begin
        if (mem.m_ready || w_timeout) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (w_grant_d) begin
        // A simultaneous read and write is treated as a store.
        r_we    <= d_wr;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_be    <= d_wr ? d_be : BE_ALL;
      end else if (w_grant_i) begin
        r_we   <= 1'b0;
        r_addr <= if_addr;
        r_be   <= BE_ALL;
      end
      if (r_state == I_BUSY) begin
        if (mem.m_ready) begin
          r_if_rdata <= mem.m_rdata;
          r_if_valid <= 1'b1;
        end else if (w_timeout) begin
          r_if_rdata <= XLEN'(NOP_INSTR);
          r_if_valid <= 1'b1;
          r_err      <= 1'b1;
        end
      end
      if (r_state == D_BUSY) begin
        if (mem.m_ready) begin
          if (!r_we) r_d_rdata <= mem.m_rdata;
          r_d_valid <= 1'b1;
        end else if (w_timeout) begin
          r_d_rdata <= '0;
          r_d_valid <= 1'b1;
          r_err     <= 1'b1;
        end
      end
    end
  end

  assign mem.m_req   = w_busy;
  assign mem.m_we    = r_we & (r_state == D_BUSY);
  assign mem.m_addr  = r_addr;
  assign mem.m_wdata = r_wdata;
  assign mem.m_be    = r_be;

  assign if_rdata = r_if_rdata;
  assign if_valid = r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;
  assign err      = r_err;

  // Stalls are combinational so a request seen in IDLE freezes the pipeline that same cycle.
  assign stall_pipe = w_d_req & ~((r_state == D_BUSY) & mem.m_ready);
  assign stall_if   = (if_req & ~((r_state == I_BUSY) & mem.m_ready)) | stall_pipe;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_conflict_cnt, r_busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
      r_busy_cnt     <= '0;
    end else begin
      if (if_req && (r_state == D_BUSY) && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (w_busy && (r_busy_cnt != '1))
        r_busy_cnt <= r_busy_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign busy_cnt     = r_busy_cnt;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter; inputs change on negedge, outputs sampled 1 ns later.
module tb_unified_mem_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_valid;
  logic            d_rd, d_wr;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]      d_be;
  logic            d_valid;
  logic            stall_if, stall_pipe;
  logic            err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]     conflict_cnt, busy_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int stall_cycles;

  unified_mem_arbiter_if #(.XLEN(XLEN)) mem_bus ();

  unified_mem_arbiter #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .stall_if   (stall_if),
    .stall_pipe (stall_pipe),
    .mem        (mem_bus),
    .err        (err)
`ifdef ARB_PERF_CNT_EN
    ,
    .conflict_cnt (conflict_cnt),
    .busy_cnt     (busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge; callers then drive inputs and wait #1 before sampling.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n             = 1'b0;
    if_req            = 1'b0;
    if_addr           = '0;
    d_rd              = 1'b0;
    d_wr              = 1'b0;
    d_addr            = '0;
    d_wdata           = '0;
    d_be              = '0;
    mem_bus.m_ready   = 1'b0;
    mem_bus.m_rdata   = '0;

    #1;
    check("rst_m_req",    32'(mem_bus.m_req), 32'h0);
    check("rst_m_be",     32'(mem_bus.m_be),  32'h0);
    check("rst_m_addr",   mem_bus.m_addr,     32'h0);
    check("rst_err",      32'(err),           32'h0);
    check("rst_if_valid", 32'(if_valid),      32'h0);
    check("rst_d_rdata",  d_rdata,            32'h0);

    next_cycle();
    rst_n = 1'b1;

    // Plain fetch, m_ready on the second busy cycle.
    stall_cycles = 0;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10; #1;
    check("f_idle_no_req", 32'(mem_bus.m_req), 32'h0);
    if (stall_if) stall_cycles++;
    next_cycle(); #1;
    check("f_m_req",  32'(mem_bus.m_req), 32'h1);
    check("f_m_addr", mem_bus.m_addr,     32'h10);
    check("f_m_we",   32'(mem_bus.m_we),  32'h0);
    check("f_m_be",   32'(mem_bus.m_be),  32'hF);
    if (stall_if) stall_cycles++;
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h0050_0093; #1;
    if (stall_if) stall_cycles++;
    check("f_stall_cycles", 32'(stall_cycles), 32'd2);
    next_cycle();
    if_req = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("f_if_valid", 32'(if_valid),     32'h1);
    check("f_if_rdata", if_rdata,          32'h0050_0093);
    check("f_idle",     32'(mem_bus.m_req), 32'h0);
    next_cycle(); #1;
    check("f_valid_pulse", 32'(if_valid), 32'h0);

    // m_ready in IDLE must not produce a completion.
    mem_bus.m_ready = 1'b1;
    next_cycle();
    mem_bus.m_ready = 1'b0; #1;
    check("idle_rdy_if_valid", 32'(if_valid), 32'h0);
    check("idle_rdy_d_valid",  32'(d_valid),  32'h0);

    // Same-cycle fetch and load: data first, fetch after d_valid.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h20; d_rd = 1'b1; d_addr = 32'h100; #1;
    check("c_stall_if0",   32'(stall_if),   32'h1);
    check("c_stall_pipe0", 32'(stall_pipe), 32'h1);
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'hCAFE_F00D; #1;
    check("c_m_addr_data", mem_bus.m_addr,      32'h100);
    check("c_m_we",        32'(mem_bus.m_we),   32'h0);
    check("c_stall_pipe1", 32'(stall_pipe),     32'h0);
    check("c_stall_if1",   32'(stall_if),       32'h1);
    next_cycle();
    d_rd = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("c_d_valid",    32'(d_valid),       32'h1);
    check("c_d_rdata",    d_rdata,            32'hCAFE_F00D);
    check("c_gap_idle",   32'(mem_bus.m_req), 32'h0);
    check("c_stall_if2",  32'(stall_if),      32'h1);
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h1111_1111; #1;
    check("c_m_addr_fetch", mem_bus.m_addr, 32'h20);
    next_cycle();
    if_req = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("c_if_valid", 32'(if_valid), 32'h1);
    check("c_if_rdata", if_rdata,      32'h1111_1111);

    // Partial store; d_rdata keeps the previous load value.
    next_cycle();
    d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; #1;
    check("s_stall_pipe", 32'(stall_pipe), 32'h1);
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h5555_5555; #1;
    check("s_m_we",    32'(mem_bus.m_we), 32'h1);
    check("s_m_be",    32'(mem_bus.m_be), 32'h3);
    check("s_m_wdata", mem_bus.m_wdata,   32'hDEAD_BEEF);
    check("s_m_addr",  mem_bus.m_addr,    32'h40);
    next_cycle();
    d_wr = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("s_d_valid", 32'(d_valid),      32'h1);
    check("s_d_rdata", d_rdata,           32'hCAFE_F00D);
    check("s_m_we_off", 32'(mem_bus.m_we), 32'h0);

    // Load arriving during a fetch waits for the fetch.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h30; #1;
    next_cycle();
    d_rd = 1'b1; d_addr = 32'h200; #1;
    check("p_m_addr_fetch", mem_bus.m_addr,   32'h30);
    check("p_stall_pipe0",  32'(stall_pipe),  32'h1);
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h2222_2222; #1;
    check("p_stall_pipe1",  32'(stall_pipe),  32'h1);
    check("p_no_preempt",   mem_bus.m_addr,   32'h30);
    next_cycle();
    if_req = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("p_if_valid",     32'(if_valid),    32'h1);
    check("p_if_rdata",     if_rdata,         32'h2222_2222);
    check("p_stall_pipe2",  32'(stall_pipe),  32'h1);
    next_cycle();
    mem_bus.m_ready = 1'b1; mem_bus.m_rdata = 32'h3333_3333; #1;
    check("p_m_addr_data",  mem_bus.m_addr,   32'h200);
    check("p_stall_pipe3",  32'(stall_pipe),  32'h0);
    next_cycle();
    d_rd = 1'b0; mem_bus.m_ready = 1'b0; #1;
    check("p_d_valid", 32'(d_valid), 32'h1);
    check("p_d_rdata", d_rdata,      32'h3333_3333);

    // Fetch timeout after MAX_WAIT cycles without m_ready.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h44; #1;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      next_cycle();
      if (k == MAX_WAIT) if_req = 1'b0;
      #1;
      if (mem_bus.m_req !== 1'b1 || err !== 1'b0) begin
        check("t_busy_wait_req", 32'(mem_bus.m_req), 32'h1);
        check("t_busy_wait_err", 32'(err),           32'h0);
      end
    end
    check("t_no_err_early", 32'(err), 32'h0);
    next_cycle(); #1;
    check("t_err",      32'(err),           32'h1);
    check("t_if_valid", 32'(if_valid),      32'h1);
    check("t_if_rdata", if_rdata,           32'h0000_0013);
    check("t_idle",     32'(mem_bus.m_req), 32'h0);
    next_cycle(); #1;
    check("t_err_sticky", 32'(err),      32'h1);
    check("t_valid_drop", 32'(if_valid), 32'h0);

    // Asynchronous reset in the middle of a data access.
    next_cycle();
    d_rd = 1'b1; d_addr = 32'h80; #1;
    next_cycle(); #1;
    check("r_busy", 32'(mem_bus.m_req), 32'h1);
    #1;
    rst_n = 1'b0; d_rd = 1'b0; #1;
    check("r_m_req",    32'(mem_bus.m_req), 32'h0);
    check("r_m_we",     32'(mem_bus.m_we),  32'h0);
    check("r_m_addr",   mem_bus.m_addr,     32'h0);
    check("r_m_wdata",  mem_bus.m_wdata,    32'h0);
    check("r_m_be",     32'(mem_bus.m_be),  32'h0);
    check("r_err",      32'(err),           32'h0);
    check("r_if_rdata", if_rdata,           32'h0);
    check("r_d_rdata",  d_rdata,            32'h0);
    check("r_d_valid",  32'(d_valid),       32'h0);
    check("r_stall",    32'(stall_pipe),    32'h0);

    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
